// File: rtl/dm_responder.sv
// dm_responder: word-organised data memory sitting behind the M-stage
// load/store port. After every reset an init sweep zeroes the array while
// dm_ready is held low; afterwards byte-lane stores and combinational reads
// are served, and every committed store emits a one-cycle trace record.
module dm_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_PC,
    input  logic [31:0] m_Addr,
    input  logic [3:0]  m_Byte_en,
    input  logic [31:0] WData,
    output logic [31:0] m_DMout,
    output logic        dm_ready,
    output logic        dm_err,
    output logic        trace_valid,
    output logic [31:0] trace_PC,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    // Byte span of the array, one bit wider so a full 32-bit window still fits.
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_ready;
    logic                    r_trace_valid;
    logic [31:0]             r_trace_pc;
    logic [31:0]             r_trace_addr;
    logic [31:0]             r_trace_data;
    logic [31:0]             r_mem [DEPTH];

    logic [31:0]             w_offset;
    logic                    w_in_range;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [31:0]             w_old_word;
    logic [31:0]             w_merged;
    logic                    w_wr_en;

    // Address decode: window check and word index within the array.
    assign w_offset   = m_Addr - BASE_ADDR;
    assign w_in_range = {1'b0, w_offset} < SPAN;
    assign w_idx      = w_offset[ADDR_WIDTH+1:2];
    assign w_old_word = r_mem[w_idx];
    assign w_wr_en    = (r_state == ST_RUN) && w_in_range && (|m_Byte_en);

    // Lane merge: enabled lanes take the store data, the rest keep old bytes.
    always_comb begin
        w_merged = w_old_word;
        for (int i = 0; i < 4; i++) begin
            if (m_Byte_en[i]) w_merged[8*i +: 8] = WData[8*i +: 8];
        end
    end

    // Init/run control, ready flag and trace record registers.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_INIT;
            r_ptr         <= '0;
            r_ready       <= 1'b0;
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
        end else begin
            r_trace_valid <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == '1) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_wr_en) begin
                        r_trace_valid <= 1'b1;
                        r_trace_pc    <= m_PC;
                        r_trace_addr  <= BASE_ADDR + {w_offset[31:2], 2'b00};
                        r_trace_data  <= w_merged;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: zeroed one word per cycle during the sweep, then stores.
    // NOTE: the array has no reset term; clearing it is the sweep's job, which
    // keeps it mappable onto plain RAM instead of thousands of reset flops.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // Outputs: reads and errors are only meaningful once the sweep is done.
    assign dm_ready    = r_ready;
    assign m_DMout     = (r_ready && w_in_range) ? w_old_word : 32'h0;
    assign dm_err      = r_ready && !w_in_range;
    assign trace_valid = r_trace_valid;
    assign trace_PC    = r_trace_pc;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;

endmodule
